// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-access stage.
//   F3_*     funct3 encodings for load/store size and signedness
//   state_t  transaction FSM states (IDLE, REQ, RESP)
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load-data alignment.
//   rdata_i   full memory word as returned by the data memory
//   off_i     byte offset of the access inside the word
//   funct3_i  access size/sign (B, H, W, BU, HU)
//   data_o    selected byte/half/word, sign- or zero-extended to XLEN
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = 2
) (
  input  logic [XLEN-1:0]  rdata_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [2:0]       funct3_i,
  output logic [XLEN-1:0]  data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Shifting the word down by the byte offset puts the addressed byte/half
  // in the low lanes; halves are only ever legal at even offsets.
  always_comb begin
    byte_v = 8'(rdata_i >> {off_i, 3'b000});
    half_v = 16'(rdata_i >> {off_i, 3'b000});
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    data_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_v};
      F3_W:    data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and write-back.
//   clk, rst                    clock (rising edge), async active-low reset
//   ex_valid_i, alu_i, rs2_i    instruction from execute: address/result, store data
//   mem_re_i, mem_we_i, funct3_i  load / store / access size+sign
//   wb_sel1_i, wb_sel2_i, pc_sel_i  selects passed through to write-back
//   stall_o                     upstream must hold while a transaction is pending
//   dmem_*                      req/gnt/rvalid data-memory interface
//   wb_valid_o, alu_o, mem_o, wb_sel1_o, wb_sel2_o, pc_sel_o, err_o
//                               registered write-back outputs (wb_valid_o pulses)
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            mem_re_i,
  input  logic            mem_we_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      wb_sel1_i,
  input  logic [1:0]      wb_sel2_i,
  input  logic [1:0]      pc_sel_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [BE_W-1:0] dmem_be_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] alu_o,
  output logic [XLEN-1:0] mem_o,
  output logic [1:0]      wb_sel1_o,
  output logic [1:0]      wb_sel2_o,
  output logic [1:0]      pc_sel_o,
  output logic            err_o
);

  localparam int OFF_W = $clog2(BE_W);

  state_t state_q, state_d;

  // write-back registers
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] mem_q, mem_d;
  logic [1:0]      sel1_q, sel1_d;
  logic [1:0]      sel2_q, sel2_d;
  logic [1:0]      pcs_q, pcs_d;
  logic            err_q, err_d;
  logic            wb_valid_q, wb_valid_d;

  // transaction hold registers, captured at accept
  logic [XLEN-1:0] hold_alu_q, hold_alu_d;
  logic [XLEN-1:0] hold_wdata_q, hold_wdata_d;
  logic [BE_W-1:0] hold_be_q, hold_be_d;
  logic            hold_we_q, hold_we_d;
  logic [2:0]      hold_f3_q, hold_f3_d;
  logic [1:0]      hold_sel1_q, hold_sel1_d;
  logic [1:0]      hold_sel2_q, hold_sel2_d;
  logic [1:0]      hold_pcs_q, hold_pcs_d;

  logic [OFF_W-1:0] off_in;
  logic             mem_op;
  logic             acc_err;
  logic [BE_W-1:0]  st_be;
  logic [XLEN-1:0]  st_wdata;
  logic [XLEN-1:0]  load_data;
  logic             in_req;

  assign off_in = alu_i[OFF_W-1:0];
  assign mem_op = mem_re_i | mem_we_i;

  // Misalignment / illegal-size detection and store lane replication.
  // Replicating the data across all lanes lets the byte enables alone pick
  // the bytes that memory actually writes.
  always_comb begin
    acc_err  = 1'b0;
    st_be    = '1;
    st_wdata = rs2_i;
    case (funct3_i)
      F3_B, F3_BU: acc_err = 1'b0;
      F3_H, F3_HU: acc_err = off_in[0];
      F3_W:        acc_err = (off_in != '0);
      default:     acc_err = 1'b1;
    endcase
    case (funct3_i[1:0])
      2'b00: begin
        st_be    = BE_W'(1) << off_in;
        st_wdata = {BE_W{rs2_i[7:0]}};
      end
      2'b01: begin
        st_be    = BE_W'(3) << off_in;
        st_wdata = {(BE_W/2){rs2_i[15:0]}};
      end
      default: begin
        st_be    = '1;
        st_wdata = rs2_i;
      end
    endcase
  end

  load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_align (
    .rdata_i  (dmem_rdata_i),
    .off_i    (hold_alu_q[OFF_W-1:0]),
    .funct3_i (hold_f3_q),
    .data_o   (load_data)
  );

  // Next-state and stall logic. stall_o drops in exactly the cycle the
  // write-back registers load so upstream advances on the same edge.
  always_comb begin
    state_d      = state_q;
    alu_d        = alu_q;
    mem_d        = mem_q;
    sel1_d       = sel1_q;
    sel2_d       = sel2_q;
    pcs_d        = pcs_q;
    err_d        = err_q;
    wb_valid_d   = 1'b0;
    hold_alu_d   = hold_alu_q;
    hold_wdata_d = hold_wdata_q;
    hold_be_d    = hold_be_q;
    hold_we_d    = hold_we_q;
    hold_f3_d    = hold_f3_q;
    hold_sel1_d  = hold_sel1_q;
    hold_sel2_d  = hold_sel2_q;
    hold_pcs_d   = hold_pcs_q;
    stall_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (mem_op && !acc_err) begin
            stall_o      = 1'b1;
            hold_alu_d   = alu_i;
            hold_wdata_d = st_wdata;
            hold_be_d    = st_be;
            hold_we_d    = mem_we_i;
            hold_f3_d    = funct3_i;
            hold_sel1_d  = wb_sel1_i;
            hold_sel2_d  = wb_sel2_i;
            hold_pcs_d   = pc_sel_i;
            state_d      = REQ;
          end else begin
            alu_d      = alu_i;
            mem_d      = '0;
            sel1_d     = wb_sel1_i;
            sel2_d     = wb_sel2_i;
            pcs_d      = pc_sel_i;
            err_d      = mem_op & acc_err;
            wb_valid_d = 1'b1;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (dmem_gnt_i) begin
          if (hold_we_q) begin
            stall_o    = 1'b0;
            alu_d      = hold_alu_q;
            mem_d      = '0;
            sel1_d     = hold_sel1_q;
            sel2_d     = hold_sel2_q;
            pcs_d      = hold_pcs_q;
            err_d      = 1'b0;
            wb_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          stall_o    = 1'b0;
          alu_d      = hold_alu_q;
          mem_d      = load_data;
          sel1_d     = hold_sel1_q;
          sel2_d     = hold_sel2_q;
          pcs_d      = hold_pcs_q;
          err_d      = 1'b0;
          wb_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      alu_q        <= '0;
      mem_q        <= '0;
      sel1_q       <= '0;
      sel2_q       <= '0;
      pcs_q        <= '0;
      err_q        <= 1'b0;
      wb_valid_q   <= 1'b0;
      hold_alu_q   <= '0;
      hold_wdata_q <= '0;
      hold_be_q    <= '0;
      hold_we_q    <= 1'b0;
      hold_f3_q    <= '0;
      hold_sel1_q  <= '0;
      hold_sel2_q  <= '0;
      hold_pcs_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_q        <= alu_d;
      mem_q        <= mem_d;
      sel1_q       <= sel1_d;
      sel2_q       <= sel2_d;
      pcs_q        <= pcs_d;
      err_q        <= err_d;
      wb_valid_q   <= wb_valid_d;
      hold_alu_q   <= hold_alu_d;
      hold_wdata_q <= hold_wdata_d;
      hold_be_q    <= hold_be_d;
      hold_we_q    <= hold_we_d;
      hold_f3_q    <= hold_f3_d;
      hold_sel1_q  <= hold_sel1_d;
      hold_sel2_q  <= hold_sel2_d;
      hold_pcs_q   <= hold_pcs_d;
    end
  end

  // The memory bus is driven only while requesting; it idles at zero.
  assign in_req       = (state_q == REQ);
  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req & hold_we_q;
  assign dmem_addr_o  = in_req ? {hold_alu_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign dmem_wdata_o = in_req ? hold_wdata_q : '0;
  assign dmem_be_o    = in_req ? hold_be_q : '0;

  assign wb_valid_o = wb_valid_q;
  assign alu_o      = alu_q;
  assign mem_o      = mem_q;
  assign wb_sel1_o  = sel1_q;
  assign wb_sel2_o  = sel2_q;
  assign pc_sel_o   = pcs_q;
  assign err_o      = err_q;

endmodule
